// File: rtl/cc_tag_seq_if.sv
// Sequencer bus for the I-cache tag write port: L2 fill/invalidate requests,
// the shared tag write port toward the ways, and the expunge return path to L2.
interface cc_tag_seq_if #(
  parameter int unsigned WAYS = 8
);
  localparam int unsigned LA_W = 37;

  logic                 fill_valid;
  logic                 fill_ready;
  logic [LA_W-1:0]      fill_addr;
  logic                 inv_valid;
  logic                 inv_ready;
  logic [LA_W-1:0]      inv_addr;
  logic                 init_req;

  logic [LA_W-1:0]      tag_phys_addr;
  logic                 tag_wen;
  logic                 tag_invalidate;
  logic                 tag_init;
  logic [WAYS-1:0]      tag_write_hit;
  logic [WAYS-1:0]      tag_exp_en;
  logic [WAYS*LA_W-1:0] tag_expun_addr;

  logic                 exp_valid;
  logic                 exp_ready;
  logic [LA_W-1:0]      exp_addr;
  logic                 busy;
  logic                 multi_hit;

  // master: L2 side plus the tag ways; slave: the sequencer
  modport master (
    output fill_valid, fill_addr, inv_valid, inv_addr, init_req,
           tag_write_hit, tag_exp_en, tag_expun_addr, exp_ready,
    input  fill_ready, inv_ready, tag_phys_addr, tag_wen, tag_invalidate,
           tag_init, exp_valid, exp_addr, busy, multi_hit
  );

  modport slave (
    input  fill_valid, fill_addr, inv_valid, inv_addr, init_req,
           tag_write_hit, tag_exp_en, tag_expun_addr, exp_ready,
    output fill_ready, inv_ready, tag_phys_addr, tag_wen, tag_invalidate,
           tag_init, exp_valid, exp_addr, busy, multi_hit
  );
endinterface

// File: rtl/cc_tag_seq.sv
// Tag-way write sequencer: init sweep, fill/invalidate arbitration, expunge FIFO to L2.
// Optional feature: define CC_TAG_SEQ_MULTIHIT_EN to build the sticky multi-hit checker.
module cc_tag_seq #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned EXP_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  cc_tag_seq_if.slave bus
);
  localparam int unsigned LA_W  = 37;
  localparam int unsigned PTR_W = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {ST_INIT, ST_DRAIN, ST_IDLE, ST_ISSUE, ST_RESP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic [1:0]            drain_cnt, drain_cnt_n;
  logic                  init_pending, init_pending_n;

  logic [LA_W-1:0]       tag_phys_addr_q, tag_phys_addr_n;
  logic                  tag_wen_q, tag_wen_n;
  logic                  tag_inv_q, tag_inv_n;
  logic                  tag_init_q, tag_init_n;
  logic                  busy_q;

  logic [LA_W-1:0]       fifo_mem [EXP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]      fifo_cnt, fifo_cnt_n;
  logic                  exp_valid_q;
  logic [LA_W-1:0]       exp_addr_q, exp_addr_n;

  logic                  push, pop;
  logic [LA_W-1:0]       push_addr;
  logic                  can_accept_c, inv_acc, fill_acc;

  // Request readies are combinational so a request can be taken the cycle IDLE is reached
  assign can_accept_c  = (state == ST_IDLE) && !init_pending && (fifo_cnt < CNT_W'(EXP_DEPTH));
  assign bus.inv_ready  = can_accept_c;
  assign bus.fill_ready = can_accept_c && !bus.inv_valid;
  assign inv_acc        = bus.inv_valid && can_accept_c;
  assign fill_acc       = bus.fill_valid && can_accept_c && !bus.inv_valid;
  assign pop            = exp_valid_q && bus.exp_ready;

  // Lowest-indexed way with an expunge wins
  always_comb begin
    push_addr = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (bus.tag_exp_en[i]) push_addr = bus.tag_expun_addr[i*LA_W +: LA_W];
    end
  end

  // Next state and next values of the registered tag-port outputs
  always_comb begin
    state_n         = state;
    idx_n           = idx;
    drain_cnt_n     = drain_cnt;
    init_pending_n  = init_pending;
    tag_phys_addr_n = tag_phys_addr_q;
    tag_wen_n       = 1'b0;
    tag_inv_n       = 1'b0;
    tag_init_n      = 1'b0;
    push            = 1'b0;

    if (bus.init_req && (state != ST_INIT) && (state != ST_DRAIN)) init_pending_n = 1'b1;

    unique case (state)
      ST_INIT: begin
        tag_init_n = 1'b1;
        if (bus.init_req) begin
          tag_phys_addr_n = '0;
          idx_n           = ADDR_WIDTH'(1);
        end else begin
          tag_phys_addr_n = LA_W'(idx);
          if (idx == IDX_LAST) begin
            state_n     = ST_DRAIN;
            drain_cnt_n = '0;
          end else begin
            idx_n = idx + ADDR_WIDTH'(1);
          end
        end
      end
      // DRAIN is entered as the last index is issued, so three counts give two quiet output cycles
      ST_DRAIN: begin
        if (bus.init_req) begin
          state_n = ST_INIT;
          idx_n   = '0;
        end else if (drain_cnt == 2'd2) begin
          state_n = ST_IDLE;
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end
      ST_IDLE: begin
        if (init_pending) begin
          state_n        = ST_INIT;
          idx_n          = '0;
          init_pending_n = 1'b0;
        end else if (inv_acc) begin
          state_n         = ST_ISSUE;
          tag_inv_n       = 1'b1;
          tag_phys_addr_n = bus.inv_addr;
        end else if (fill_acc) begin
          state_n         = ST_ISSUE;
          tag_wen_n       = 1'b1;
          tag_phys_addr_n = bus.fill_addr;
        end
      end
      ST_ISSUE: state_n = ST_RESP;
      ST_RESP: begin
        push    = |bus.tag_exp_en;
        state_n = ST_IDLE;
      end
      default: state_n = ST_INIT;
    endcase
  end

  // FIFO bookkeeping; the head is registered so exp_addr stays stable until popped
  always_comb begin
    rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    case ({push, pop})
      2'b10:   fifo_cnt_n = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_n = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_n = fifo_cnt;
    endcase
    if (fifo_cnt_n == '0)                 exp_addr_n = exp_addr_q;
    else if (push && (rd_ptr_n == wr_ptr)) exp_addr_n = push_addr;
    else                                  exp_addr_n = fifo_mem[rd_ptr_n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_INIT;
      idx             <= '0;
      drain_cnt       <= '0;
      init_pending    <= 1'b0;
      tag_phys_addr_q <= '0;
      tag_wen_q       <= 1'b0;
      tag_inv_q       <= 1'b0;
      tag_init_q      <= 1'b0;
      busy_q          <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      exp_valid_q     <= 1'b0;
      exp_addr_q      <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      drain_cnt       <= drain_cnt_n;
      init_pending    <= init_pending_n;
      tag_phys_addr_q <= tag_phys_addr_n;
      tag_wen_q       <= tag_wen_n;
      tag_inv_q       <= tag_inv_n;
      tag_init_q      <= tag_init_n;
      busy_q          <= (state_n != ST_IDLE);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr          <= rd_ptr_n;
      fifo_cnt        <= fifo_cnt_n;
      exp_valid_q     <= (fifo_cnt_n != '0);
      exp_addr_q      <= exp_addr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_addr;
  end

`ifdef CC_TAG_SEQ_MULTIHIT_EN
  logic multi_hit_q;

  // Two ways claiming the same line is a tag-array corruption; remember it until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      multi_hit_q <= 1'b0;
    end else if ((state == ST_RESP) &&
                 ((bus.tag_write_hit & (bus.tag_write_hit - WAYS'(1))) != '0)) begin
      multi_hit_q <= 1'b1;
    end
  end

  assign bus.multi_hit = multi_hit_q;
`else
  assign bus.multi_hit = 1'b0;
`endif

  assign bus.tag_phys_addr  = tag_phys_addr_q;
  assign bus.tag_wen        = tag_wen_q;
  assign bus.tag_invalidate = tag_inv_q;
  assign bus.tag_init       = tag_init_q;
  assign bus.busy           = busy_q;
  assign bus.exp_valid      = exp_valid_q;
  assign bus.exp_addr       = exp_addr_q;
endmodule

// File: tb/tb_cc_tag_seq.sv
// Self-checking bench for cc_tag_seq: vector table of requests plus hand-written
// sequences for init sweep, arbitration, FIFO backpressure, init-during-request and reset.
module tb_cc_tag_seq;
  localparam int unsigned WAYS       = 8;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned EXP_DEPTH  = 4;
  localparam int unsigned LA_W       = 37;
  localparam int          SETS       = 1 << ADDR_WIDTH;
`ifdef CC_TAG_SEQ_MULTIHIT_EN
  localparam logic MH_EXP = 1'b1;
`else
  localparam logic MH_EXP = 1'b0;
`endif

  typedef logic [LA_W-1:0] la_t;
  typedef struct {
    logic            inv;
    la_t             addr;
    logic [WAYS-1:0] en;
    logic [WAYS-1:0] hit;
    la_t             victim;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  la_t  exp_q[$];
  vec_t vecs[7];

  cc_tag_seq_if #(.WAYS(WAYS)) bus ();

  cc_tag_seq #(.WAYS(WAYS), .ADDR_WIDTH(ADDR_WIDTH), .EXP_DEPTH(EXP_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Every L2-side pop is compared against the oldest expected expunge
  always @(negedge clk) begin
    if (rst && bus.exp_valid && bus.exp_ready) begin
      la_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL exp_unexpected: got 0x%0h, required no entry", bus.exp_addr);
      end else begin
        e = exp_q.pop_front();
        check("exp_addr", 64'(bus.exp_addr), 64'(e));
      end
    end
  end

  // Lowest enabled way reports the victim; other ways report distinct decoys
  task automatic set_ways(input logic [WAYS-1:0] en, input logic [WAYS-1:0] hit, input la_t victim,
                          output la_t pushed, output logic has_push);
    has_push = 1'b0;
    pushed   = '0;
    bus.tag_exp_en    = en;
    bus.tag_write_hit = hit;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (en[i] && !has_push) begin
        bus.tag_expun_addr[i*LA_W +: LA_W] = victim;
        pushed   = victim;
        has_push = 1'b1;
      end else begin
        bus.tag_expun_addr[i*LA_W +: LA_W] = victim ^ 37'h10_0000_0000 ^ la_t'(i + 1);
      end
    end
  endtask

  task automatic clear_ways();
    bus.tag_exp_en     = '0;
    bus.tag_write_hit  = '0;
    bus.tag_expun_addr = '0;
  endtask

  task automatic do_req(input vec_t v, input string tag);
    la_t  pushed;
    logic has_push;
    int   waited;
    @(posedge clk); #1;
    if (v.inv) begin bus.inv_valid = 1'b1; bus.inv_addr = v.addr; end
    else begin bus.fill_valid = 1'b1; bus.fill_addr = v.addr; end
    waited = 0;
    @(negedge clk);
    while (!(v.inv ? bus.inv_ready : bus.fill_ready) && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) begin
      fail_now({tag, " accept"});
      bus.inv_valid  = 1'b0;
      bus.fill_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.inv_valid  = 1'b0;
    bus.fill_valid = 1'b0;
    set_ways(v.en, v.hit, v.victim, pushed, has_push);
    if (has_push) exp_q.push_back(pushed);
    @(negedge clk);
    check({tag, " issue_ctl"}, 64'({bus.tag_wen, bus.tag_invalidate, bus.tag_init}),
          64'(v.inv ? 3'b010 : 3'b100));
    check({tag, " issue_addr"}, 64'(bus.tag_phys_addr), 64'(v.addr));
    @(negedge clk);
    check({tag, " pulse_end"}, 64'({bus.tag_wen, bus.tag_invalidate, bus.tag_init}), 64'(0));
    @(posedge clk); #1;
    clear_ways();
    @(negedge clk);
    if (has_push) check({tag, " exp_valid"}, 64'(bus.exp_valid), 64'(1));
  endtask

  initial begin
    la_t  pushed;
    logic has_push;
    vec_t v;
    int   k;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.fill_valid = 1'b0; bus.fill_addr = '0;
    bus.inv_valid  = 1'b0; bus.inv_addr  = '0;
    bus.init_req   = 1'b0; bus.exp_ready = 1'b1;
    clear_ways();

    vecs[0] = '{1'b0, 37'h0_000A_BCDE, 8'h08, 8'h00, 37'h0_0001_2345};
    vecs[1] = '{1'b0, 37'h1F_FFFF_FFFF, 8'h00, 8'h00, 37'h0_0000_0BAD};
    vecs[2] = '{1'b1, 37'h0_1234_5678, 8'h40, 8'h40, 37'h0_1234_5678};
    vecs[3] = '{1'b1, 37'h0_0000_0001, 8'h00, 8'h00, 37'h0_0000_0001};
    vecs[4] = '{1'b0, 37'h0A_AAAA_AAAA, 8'h28, 8'h00, 37'h15_5555_5555};
    vecs[5] = '{1'b0, 37'h00_0000_0080, 8'h81, 8'h00, 37'h01_0000_0001};
    vecs[6] = '{1'b1, 37'h03_0000_0300, 8'hFF, 8'h01, 37'h07_7777_7777};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst busy", 64'(bus.busy), 64'(1));
    check("rst tag_ctl", 64'({bus.tag_wen, bus.tag_invalidate, bus.tag_init}), 64'(0));
    check("rst tag_addr", 64'(bus.tag_phys_addr), 64'(0));
    check("rst readies", 64'({bus.fill_ready, bus.inv_ready}), 64'(0));
    check("rst exp", 64'({bus.exp_valid, bus.exp_addr}), 64'(0));
    check("rst multi_hit", 64'(bus.multi_hit), 64'(0));

    // Power-up sweep
    rst = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      check("sweep", 64'({bus.tag_init, bus.fill_ready, bus.inv_ready, bus.busy, bus.tag_phys_addr}),
            64'({1'b1, 1'b0, 1'b0, 1'b1, la_t'(i)}));
    end
    @(negedge clk);
    check("drain1", 64'({bus.tag_init, bus.busy, bus.inv_ready}), 64'(3'b010));
    @(negedge clk);
    check("drain2", 64'({bus.tag_init, bus.busy, bus.inv_ready}), 64'(3'b010));
    @(negedge clk);
    check("idle", 64'({bus.tag_init, bus.busy, bus.inv_ready}), 64'(3'b001));

    // Table of single requests with exp_ready held high
    foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));
    check("no multi_hit on single hits", 64'(bus.multi_hit), 64'(0));

    // Arbitration: invalidate beats fill, fill follows 3 cycles later
    @(posedge clk); #1;
    bus.inv_valid = 1'b1;  bus.inv_addr  = 37'h0_0000_1111;
    bus.fill_valid = 1'b1; bus.fill_addr = 37'h0_0000_2222;
    @(negedge clk);
    check("arb readies", 64'({bus.inv_ready, bus.fill_ready}), 64'(2'b10));
    @(posedge clk); #1;
    bus.inv_valid = 1'b0;
    @(negedge clk);
    check("arb inv pulse", 64'({bus.tag_wen, bus.tag_invalidate, bus.tag_phys_addr}),
          64'({2'b01, 37'h0_0000_1111}));
    k = 1;
    while (!bus.fill_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("arb fill gap", 64'(k), 64'(3));
    check("arb inv miss no exp", 64'(bus.exp_valid), 64'(0));
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    @(negedge clk);
    check("arb fill pulse", 64'({bus.tag_wen, bus.tag_invalidate, bus.tag_phys_addr}),
          64'({2'b10, 37'h0_0000_2222}));
    repeat (2) @(negedge clk);

    // FIFO backpressure with EXP_DEPTH entries outstanding
    @(posedge clk); #1;
    bus.exp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, la_t'(37'h0_0000_3000 + i), 8'h01 << i, 8'h00, la_t'(37'h0_0ABC_0000 + i)};
      do_req(v, $sformatf("bp%0d", i));
    end
    @(posedge clk); #1;
    bus.fill_valid = 1'b1; bus.fill_addr = 37'h0_0000_3004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp full ready", 64'({bus.fill_ready, bus.inv_ready, bus.exp_valid}), 64'(3'b001));
    end
    @(posedge clk); #1;
    bus.exp_ready = 1'b1;
    @(posedge clk); #1;
    bus.exp_ready = 1'b0;
    @(negedge clk);
    check("bp ready after pop", 64'(bus.fill_ready), 64'(1));
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    set_ways(8'h10, 8'h00, 37'h0_0ABC_0004, pushed, has_push);
    exp_q.push_back(pushed);
    @(negedge clk);
    check("bp 5th pulse", 64'({bus.tag_wen, bus.tag_phys_addr}), 64'({1'b1, 37'h0_0000_3004}));
    repeat (2) @(posedge clk);
    #1;
    clear_ways();
    bus.exp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp drained", 64'(exp_q.size()), 64'(0));

    // init_req during ISSUE; ways 1 and 6 both hit
    @(posedge clk); #1;
    bus.fill_valid = 1'b1; bus.fill_addr = 37'h0_0000_4000;
    @(negedge clk);
    check("ir ready", 64'(bus.fill_ready), 64'(1));
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    bus.init_req   = 1'b1;
    set_ways(8'h42, 8'h42, 37'h0_0000_4242, pushed, has_push);
    exp_q.push_back(pushed);
    @(negedge clk);
    check("ir issue", 64'({bus.tag_wen, bus.tag_init}), 64'(2'b10));
    @(posedge clk); #1;
    bus.init_req = 1'b0;
    @(negedge clk);
    check("ir resp", 64'({bus.tag_wen, bus.tag_init}), 64'(0));
    @(posedge clk); #1;
    clear_ways();
    @(negedge clk);
    check("ir exp_valid", 64'(bus.exp_valid), 64'(1));
    check("ir pending blocks", 64'({bus.fill_ready, bus.inv_ready}), 64'(0));
    check("ir multi_hit", 64'(bus.multi_hit), 64'(MH_EXP));
    k = 0;
    while (!bus.tag_init && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k >= 10) fail_now("ir init start");
    check("ir first idx", 64'(bus.tag_phys_addr), 64'(0));
    k = 1;
    @(negedge clk);
    while (bus.tag_init && k < SETS + 10) begin
      check("ir resweep idx", 64'(bus.tag_phys_addr), 64'(k));
      k++;
      @(negedge clk);
    end
    check("ir sweep len", 64'(k), 64'(SETS));
    k = 0;
    while (bus.busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ir busy falls", 64'(k), 64'(2));
    check("ir multi_hit sticky", 64'(bus.multi_hit), 64'(MH_EXP));

    // Async reset during RESP drops the pending expunge
    @(posedge clk); #1;
    bus.fill_valid = 1'b1; bus.fill_addr = 37'h0_0000_5000;
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    set_ways(8'h04, 8'h00, 37'h0_0000_5555, pushed, has_push);
    @(negedge clk);
    check("ar issue", 64'(bus.tag_wen), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar outputs", 64'({bus.busy, bus.tag_wen, bus.exp_valid, bus.multi_hit, bus.fill_ready}),
          64'(5'b10000));
    repeat (2) @(negedge clk);
    clear_ways();
    rst = 1'b1;
    @(negedge clk);
    check("ar restart", 64'({bus.tag_init, bus.tag_phys_addr}), 64'({1'b1, 37'h0}));
    k = 0;
    while (bus.busy && k < SETS + 20) begin
      @(negedge clk);
      k++;
    end
    check("ar sweep done", 64'({bus.busy, bus.exp_valid}), 64'(0));

    check("queue empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
